qif_synapse: RTL and testbench

- Synaptic current generator directly upstream of the QIF neuron; produces the neuron's 8-bit signed synaptic current I_syn.
- Accepts spike events from up to N_IN presynaptic sources through a valid/ready handshake and adds a programmable per-source signed weight.
- Applies periodic exponential leak to the accumulated current.
- Saturates the result to the signed 8-bit range.

---
 rtl/qif_synapse.sv | 151 +++++++++++++++
 tb/tb_qif_synapse.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qif_synapse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : qif_synapse
//  Brief    : Synaptic current generator for the QIF neuron. It accepts spike
//             events over a valid/ready handshake and adds a programmable
//             signed weight for each source. It applies a periodic arithmetic
//             leak and saturates the 8-bit signed current.
//  Revision : 1.0 - initial release
// ============================================================================
module qif_synapse #(
   parameter int  N_IN        = 4,
   parameter int  DECAY_SHIFT = 2,
   parameter int  TICK_DIV    = 4,
   localparam int IDX_W       = $clog2(N_IN)
) (
   input  logic             clk,
   input  logic             rst_n,        // active-high asynchronous reset
   input  logic             spike_valid,
   input  logic [IDX_W-1:0] spike_idx,
   output logic             spike_ready,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   output logic [7:0]       I_syn,
   output logic             sat_flag
);

   localparam int                C_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICK_DIV - 1);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DECAY = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_run;          // low until the first clock after reset
   logic [C_TICK_W-1:0] r_tick;
   logic [C_TICK_W-1:0] w_tick_nxt;
   logic                w_ready;
   logic                w_decay;

   logic [7:0]          r_w [N_IN];
   logic [7:0]          w_wsel;
   logic [8:0]          w_sum;
   logic                w_accept;

   logic signed [7:0]   r_isyn;
   logic signed [7:0]   w_isyn_nxt;
   logic signed [7:0]   w_leak;
   logic                r_sat;
   logic                w_sat_nxt;

   // State, tick counter and run flag registers. The run flag keeps spike_ready
   // low until the first clock edge after reset is released.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= ST_ACCUM;
         r_tick  <= '0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_run   <= 1'b1;
      end
   end

   // Next-state logic. ACCUM counts TICK_DIV cycles, then DECAY lasts one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_ready     = 1'b0;
      w_decay     = 1'b0;
      if (r_run) begin
         case (r_state)
            ST_ACCUM: begin
               w_ready = 1'b1;
               if (r_tick == C_TICK_LAST) begin
                  w_tick_nxt  = '0;
                  w_state_nxt = ST_DECAY;
               end else begin
                  w_tick_nxt  = r_tick + 1'b1;
               end
            end
            ST_DECAY: begin
               w_decay     = 1'b1;
               w_state_nxt = ST_ACCUM;
            end
            default: w_state_nxt = ST_ACCUM;
         endcase
      end
   end

   // Weight table. A write is allowed in any state. A spike that arrives in
   // the same cycle still reads the old value, because the write lands at the
   // clock edge.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < N_IN; i++) begin
            r_w[i] <= '0;
         end
      end else if (wr_en) begin
         r_w[wr_idx] <= wr_data;
      end
   end

   // Current update. Leak and accumulate cannot overlap because spike_ready is
   // low in DECAY. The 9-bit sum is clamped by looking at its top two bits.
   always_comb begin
      w_accept   = spike_valid && w_ready;
      w_wsel     = r_w[spike_idx];
      w_sum      = {r_isyn[7], r_isyn} + {w_wsel[7], w_wsel};
      w_leak     = r_isyn - (r_isyn >>> DECAY_SHIFT);
      w_isyn_nxt = r_isyn;
      w_sat_nxt  = 1'b0;
      if (w_decay) begin
         w_isyn_nxt = w_leak;
      end else if (w_accept) begin
         case (w_sum[8:7])
            2'b01: begin
               w_isyn_nxt = 8'sd127;
               w_sat_nxt  = 1'b1;
            end
            2'b10: begin
               w_isyn_nxt = -8'sd128;
               w_sat_nxt  = 1'b1;
            end
            default: w_isyn_nxt = w_sum[7:0];
         endcase
      end
   end

   // Registered current and the one-cycle saturation pulse.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_isyn <= '0;
         r_sat  <= 1'b0;
      end else begin
         r_isyn <= w_isyn_nxt;
         r_sat  <= w_sat_nxt;
      end
   end

   assign spike_ready = w_ready;
   assign I_syn       = r_isyn;
   assign sat_flag    = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_qif_synapse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_qif_synapse
//  Brief    : Directed self-checking bench for qif_synapse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qif_synapse;

   logic       clk;
   logic       rst_n;
   logic       spike_valid;
   logic [1:0] spike_idx;
   logic       spike_ready;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [7:0] wr_data;
   logic [7:0] I_syn;
   logic       sat_flag;

   int n_total;
   int n_bad;

   qif_synapse #(
      .N_IN        (4),
      .DECAY_SHIFT (2),
      .TICK_DIV    (4)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spike_valid (spike_valid),
      .spike_idx   (spike_idx),
      .spike_ready (spike_ready),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .I_syn       (I_syn),
      .sat_flag    (sat_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int isyn();
      return int'($signed(I_syn));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      spike_valid = 1'b0;
      wr_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ready", int'(spike_ready), 0);
         chk("rst_isyn", isyn(), 0);
         chk("rst_sat", int'(sat_flag), 0);
      end
      rst_n = 1'b0;
      chk("rel_ready_pre_edge", int'(spike_ready), 0);
      step();
      chk("rel_ready_first_edge", int'(spike_ready), 1);
   endtask

   task automatic wr(input logic [1:0] idx, input logic [7:0] data);
      wr_en = 1'b1;
      wr_idx = idx;
      wr_data = data;
      step();
      wr_en = 1'b0;
   endtask

   // Run to the first ACCUM cycle after the next DECAY cycle.
   task automatic align();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (!spike_ready) begin
            step();
            found = 1'b1;
            break;
         end
         step();
      end
      if (!found) chk("align_timeout", 0, 1);
   endtask

   // Hold a spike until it is accepted, then drop valid.
   task automatic send(input logic [1:0] idx);
      bit done;
      done = 1'b0;
      spike_valid = 1'b1;
      spike_idx = idx;
      for (int i = 0; i < 10; i++) begin
         if (spike_ready) begin
            step();
            done = 1'b1;
            break;
         end
         step();
      end
      spike_valid = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   initial begin
      n_total = 0;
      n_bad = 0;
      rst_n = 1'b1;
      spike_valid = 1'b0;
      spike_idx = '0;
      wr_en = 1'b0;
      wr_idx = '0;
      wr_data = '0;

      // Reset, then idle: DECAY appears every 5th cycle and I_syn stays 0.
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("idle_ready_%0d", k), int'(spike_ready), (k % 5 != 0) ? 1 : 0);
         chk($sformatf("idle_isyn_%0d", k), isyn(), 0);
         step();
      end

      // Single spike, followed by two decay steps.
      wr(2'd1, 8'd20);
      align();
      spike_valid = 1'b1;
      spike_idx = 2'd1;
      step();
      spike_valid = 1'b0;
      chk("single_isyn", isyn(), 20);
      chk("single_sat", int'(sat_flag), 0);
      align();
      chk("decay1", isyn(), 15);
      align();
      chk("decay2", isyn(), 12);

      // Positive saturation.
      do_reset();
      wr(2'd0, 8'd100);
      align();
      send(2'd0);
      chk("pos_first", isyn(), 100);
      chk("pos_first_sat", int'(sat_flag), 0);
      send(2'd0);
      chk("pos_clamp", isyn(), 127);
      chk("pos_clamp_sat", int'(sat_flag), 1);
      step();
      chk("pos_sat_pulse_end", int'(sat_flag), 0);

      // Negative saturation.
      do_reset();
      wr(2'd2, 8'h9C);
      align();
      send(2'd2);
      chk("neg_first", isyn(), -100);
      chk("neg_first_sat", int'(sat_flag), 0);
      send(2'd2);
      chk("neg_clamp1", isyn(), -128);
      chk("neg_clamp1_sat", int'(sat_flag), 1);
      send(2'd2);
      chk("neg_clamp2", isyn(), -128);
      chk("neg_clamp2_sat", int'(sat_flag), 1);

      // A spike held into DECAY stalls until the next ACCUM cycle.
      do_reset();
      wr(2'd3, 8'd8);
      align();
      step();
      step();
      step();
      spike_valid = 1'b1;
      spike_idx = 2'd3;
      chk("stall_ready_pre", int'(spike_ready), 1);
      step();
      chk("stall_first", isyn(), 8);
      chk("stall_ready_decay", int'(spike_ready), 0);
      step();
      chk("stall_after_decay", isyn(), 6);
      chk("stall_ready_accum", int'(spike_ready), 1);
      step();
      spike_valid = 1'b0;
      chk("stall_accepted", isyn(), 14);
      step();
      chk("stall_once", isyn(), 14);

      // A write and a spike to the same index in one cycle use the old weight.
      do_reset();
      wr(2'd3, 8'd10);
      align();
      wr_en = 1'b1;
      wr_idx = 2'd3;
      wr_data = 8'd50;
      spike_valid = 1'b1;
      spike_idx = 2'd3;
      step();
      wr_en = 1'b0;
      spike_valid = 1'b0;
      chk("collide_old_weight", isyn(), 10);
      send(2'd3);
      chk("collide_new_weight", isyn(), 60);

      // Asynchronous reset between clock edges.
      spike_valid = 1'b1;
      spike_idx = 2'd3;
      #2;
      rst_n = 1'b1;
      #1;
      chk("async_isyn", isyn(), 0);
      chk("async_sat", int'(sat_flag), 0);
      chk("async_ready", int'(spike_ready), 0);
      step();
      step();
      spike_valid = 1'b0;
      rst_n = 1'b0;
      step();
      chk("post_rst_ready", int'(spike_ready), 1);
      send(2'd3);
      chk("post_rst_weight_zero", isyn(), 0);
      chk("post_rst_sat", int'(sat_flag), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
